// File: rtl/dds_waveform_gen.sv
// -----------------------------------------------------------------------------
// dds_waveform_gen
//
// Direct-digital-synthesis sample generator feeding dac_module.
//
// A phase accumulator advances by the tuning word on every sample strobe. The
// accumulator value (taken before the update) travels down a three-stage
// pipeline. S1 presents the sine ROM address. S2 waits out the ROM's one-cycle
// read latency. S3 builds the raw waveform, scales it about midscale and
// registers it into dac_value. Strobes may arrive on every cycle.
//
// Handshake: dac_valid is a one-cycle, valid-only pulse with no ready. The
// consumer must take dac_value in the cycle dac_valid is high. Between pulses
// dac_value holds the last sample.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   sample_en  one-cycle sample strobe
//   freq_up    pulse: tuning word += FW_STEP (saturates at FW_MAX)
//   freq_down  pulse: tuning word -= FW_STEP (saturates at FW_MIN)
//   wave_next  pulse: waveform select +1 mod 4
//   amp_next   pulse: attenuation shift +1 mod 4
//   rom_addr   sine ROM address (registered, S1)
//   rom_q      sine ROM data, valid one cycle after rom_addr
//   dac_value  unsigned sample, midscale 128
//   dac_valid  one-cycle pulse when dac_value updates
//   freq_word  current tuning word
//   wave_sel   0 sine, 1 square, 2 triangle, 3 sawtooth
//   amp_shift  current attenuation shift 0..3
// -----------------------------------------------------------------------------
module dds_waveform_gen #(
  parameter int ACC_W      = 24,
  parameter int FW_W       = 16,
  parameter int FW_DEFAULT = 16777,
  parameter int FW_STEP    = 1678,
  parameter int FW_MIN     = 1678,
  parameter int FW_MAX     = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic            freq_up,
  input  logic            freq_down,
  input  logic            wave_next,
  input  logic            amp_next,
  output logic [10:0]     rom_addr,
  input  logic [7:0]      rom_q,
  output logic [7:0]      dac_value,
  output logic            dac_valid,
  output logic [FW_W-1:0] freq_word,
  output logic [1:0]      wave_sel,
  output logic [1:0]      amp_shift
);

  localparam int ADDR_W = 11;
  localparam int PH_W   = 9;

  localparam logic [FW_W-1:0] FW_DEFAULT_W = FW_W'(FW_DEFAULT);
  localparam logic [FW_W-1:0] FW_STEP_W    = FW_W'(FW_STEP);
  localparam logic [FW_W-1:0] FW_MIN_W     = FW_W'(FW_MIN);
  localparam logic [FW_W-1:0] FW_MAX_W     = FW_W'(FW_MAX);

  // One extra bit so the saturation compares cannot wrap.
  localparam logic [FW_W:0] FW_STEP_X  = (FW_W+1)'(FW_STEP);
  localparam logic [FW_W:0] FW_MAX_X   = (FW_W+1)'(FW_MAX);
  localparam logic [FW_W:0] FW_FLOOR_X = (FW_W+1)'(FW_MIN + FW_STEP);

  localparam logic [7:0] MIDSCALE = 8'd128;

  // ---------------------------------------------------------------------------
  // Control registers: tuning word, waveform select, amplitude shift
  // ---------------------------------------------------------------------------
  logic [FW_W:0]   fw_up_sum;
  logic [FW_W-1:0] fw_next;

  always_comb begin
    fw_up_sum = {1'b0, freq_word} + FW_STEP_X;
    fw_next   = freq_word;
    if (freq_up && !freq_down) begin
      if (fw_up_sum > FW_MAX_X) fw_next = FW_MAX_W;
      else                      fw_next = fw_up_sum[FW_W-1:0];
    end else if (freq_down && !freq_up) begin
      // freq_word - FW_STEP < FW_MIN  <=>  freq_word < FW_MIN + FW_STEP
      if ({1'b0, freq_word} < FW_FLOOR_X) fw_next = FW_MIN_W;
      else                                fw_next = freq_word - FW_STEP_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_word <= FW_DEFAULT_W;
      wave_sel  <= 2'd0;
      amp_shift <= 2'd0;
    end else begin
      freq_word <= fw_next;
      if (wave_next) wave_sel  <= wave_sel + 2'd1;
      if (amp_next)  amp_shift <= amp_shift + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase accumulator. A strobe in the same cycle as a tuning command still
  // adds the old freq_word, because fw_next only lands on the same edge.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (sample_en) begin
      acc <= acc + {{(ACC_W-FW_W){1'b0}}, freq_word};
    end
  end

  // ---------------------------------------------------------------------------
  // S1: latch the pre-update phase as ROM address plus a 9-bit phase copy
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0] p1;
  logic            v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      p1       <= '0;
      v1       <= 1'b0;
    end else begin
      v1 <= sample_en;
      if (sample_en) begin
        rom_addr <= acc[ACC_W-1 -: ADDR_W];
        p1       <= acc[ACC_W-1 -: PH_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: the ROM is reading the S1 address; carry phase and valid alongside it
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0] p2;
  logic            v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p2 <= '0;
      v2 <= 1'b0;
    end else begin
      p2 <= p1;
      v2 <= v1;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: waveform shaping and scaling. wave_sel and amp_shift are read here, so
  // a change affects the next sample that leaves the pipeline.
  // ---------------------------------------------------------------------------
  logic [7:0] raw;
  logic [7:0] scaled;

  always_comb begin
    raw = rom_q;
    case (wave_sel)
      2'd0: raw = rom_q;
      2'd1: raw = p2[8] ? 8'h00 : 8'hFF;
      2'd2: raw = p2[8] ? ~p2[7:0] : p2[7:0];
      2'd3: raw = p2[8:1];
      default: raw = rom_q;
    endcase
  end

  // (raw >> s) spans 0..(255 >> s), and the offset 128 - (128 >> s) recentres
  // it on 128. The largest result is 255 at s = 0, so 8 bits suffice.
  always_comb begin
    scaled = (raw >> amp_shift) + (MIDSCALE - (MIDSCALE >> amp_shift));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_value <= MIDSCALE;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= v2;
      if (v2) dac_value <= scaled;
    end
  end

endmodule

// File: tb/tb_dds_waveform_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_waveform_gen
//
// Randomised and directed stimulus. A behavioural model predicts every
// visible output from the generator's arithmetic rules. Each strobe records
// its phase and the cycle its sample is due. On that cycle the model forms
// the sample with plain integer arithmetic and pushes it onto exp_q. One
// checker process compares all outputs after every clock edge. Directed
// sections add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_dds_waveform_gen;

  localparam int FW_DEFAULT = 16777;
  localparam int FW_STEP    = 1678;
  localparam int FW_MIN     = 1678;
  localparam int FW_MAX     = 65535;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sample_en = 1'b0;
  logic        freq_up   = 1'b0;
  logic        freq_down = 1'b0;
  logic        wave_next = 1'b0;
  logic        amp_next  = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  dac_value;
  logic        dac_valid;
  logic [15:0] freq_word;
  logic [1:0]  wave_sel;
  logic [1:0]  amp_shift;

  dds_waveform_gen dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .freq_up   (freq_up),
    .freq_down (freq_down),
    .wave_next (wave_next),
    .amp_next  (amp_next),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .dac_value (dac_value),
    .dac_valid (dac_valid),
    .freq_word (freq_word),
    .wave_sel  (wave_sel),
    .amp_shift (amp_shift)
  );

  // Sine ROM stand-in: random contents, registered read. Entry 0 is 0x80.
  logic [7:0] rom [0:2047];
  always @(posedge clk) rom_q <= rom[rom_addr];

  // ---------------- counters / check helper ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned acc;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [7:0]  exp_q[$];
  int unsigned m_acc;
  int          m_fw, m_wave, m_amp, cyc;
  bit          exp_valid;
  int          exp_addr;
  logic [7:0]  exp_dac;

  function automatic int exp_sample(int unsigned acc, int wave, int amp);
    int p;
    int raw;
    int d;
    p = int'(acc >> 15);
    d = 1 << amp;
    case (wave)
      0:       raw = int'(rom[acc >> 13]);
      1:       raw = (p < 256) ? 255 : 0;
      2:       raw = (p < 256) ? p : 511 - p;
      default: raw = p / 2;
    endcase
    return raw / d + 128 - 128 / d;
  endfunction

  task automatic model_reset();
    m_acc     = 0;
    m_fw      = FW_DEFAULT;
    m_wave    = 0;
    m_amp     = 0;
    pend.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_addr  = 0;
    exp_dac   = 8'd128;
  endtask

  // Predicts the state right after the coming rising edge from the inputs
  // just driven.
  task automatic model_step();
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_q.push_back(8'(exp_sample(pend[0].acc, m_wave, m_amp)));
      exp_valid = 1'b1;
      pend.delete(0);
    end
    if (sample_en) begin
      pend.push_back(pend_t'{acc: m_acc, due: cyc + 2});
      exp_addr = int'(m_acc >> 13);
      m_acc    = (m_acc + int'(m_fw)) % 32'h0100_0000;
    end
    if (freq_up && !freq_down)
      m_fw = (m_fw + FW_STEP > FW_MAX) ? FW_MAX : m_fw + FW_STEP;
    else if (freq_down && !freq_up)
      m_fw = (m_fw - FW_STEP < FW_MIN) ? FW_MIN : m_fw - FW_STEP;
    if (wave_next) m_wave = (m_wave + 1) % 4;
    if (amp_next)  m_amp  = (m_amp + 1) % 4;
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (exp_valid && exp_q.size() > 0) exp_dac = exp_q.pop_front();
    check("dac_valid", 32'(dac_valid), 32'(exp_valid));
    check("dac_value", 32'(dac_value), 32'(exp_dac));
    check("freq_word", 32'(freq_word), 32'(m_fw));
    check("wave_sel",  32'(wave_sel),  32'(m_wave));
    check("amp_shift", 32'(amp_shift), 32'(m_amp));
    check("rom_addr",  32'(rom_addr),  32'(exp_addr));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(bit se, bit fu, bit fd, bit wn, bit an);
    @(negedge clk);
    sample_en = se;
    freq_up   = fu;
    freq_down = fd;
    wave_next = wn;
    amp_next  = an;
    model_step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    sample_en = 0; freq_up = 0; freq_down = 0; wave_next = 0; amp_next = 0;
    model_step();
  endtask

  task automatic full_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_en = 0; freq_up = 0; freq_down = 0; wave_next = 0; amp_next = 0;
    model_step();
    idle(2);
    release_rst();
  endtask

  // Wait for the edge that follows the last tick, then sample just after it.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously while a sample is still in the pipeline.
  task automatic mid_reset();
    tick(1, 0, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_dac_value", 32'(dac_value), 32'd128);
    check("async_rst_dac_valid", 32'(dac_valid), 32'd0);
    check("async_rst_freq_word", 32'(freq_word), 32'd16777);
    check("async_rst_rom_addr",  32'(rom_addr),  32'd0);
    idle(2);
    release_rst();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'h80;
    model_reset();
    repeat (3) @(negedge clk);
    release_rst();

    // Reset, then idle.
    idle(4);
    after_edge();
    check("rst_dac_value", 32'(dac_value), 32'd128);
    check("rst_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_freq_word", 32'(freq_word), 32'd16777);
    check("rst_wave_sel",  32'(wave_sel),  32'd0);
    check("rst_amp_shift", 32'(amp_shift), 32'd0);
    check("rst_rom_addr",  32'(rom_addr),  32'd0);

    // Sine at phase 0 reads ROM entry 0x80 and yields 128.
    tick(1, 0, 0, 0, 0);
    idle(2);
    after_edge();
    check("sine_addr0_valid", 32'(dac_valid), 32'd1);
    check("sine_addr0_value", 32'(dac_value), 32'd128);

    // Sawtooth, three freq_up, then one strobe. Latency is exactly 3 cycles.
    full_reset();
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    after_edge();
    check("saw_freq_word", 32'(freq_word), 32'd21811);
    check("saw_lat1_valid", 32'(dac_valid), 32'd0);
    idle(1);
    after_edge();
    check("saw_lat2_valid", 32'(dac_valid), 32'd0);
    idle(1);
    after_edge();
    check("saw_lat3_valid", 32'(dac_valid), 32'd1);
    check("saw_lat3_value", 32'(dac_value), 32'd0);
    // The second strobe addresses with acc = 0x005533, so rom_addr is 2.
    tick(1, 0, 0, 0, 0);
    after_edge();
    check("saw_acc_rom_addr", 32'(rom_addr), 32'd2);
    idle(3);

    // Tuning-word saturation and simultaneous up/down.
    for (int i = 0; i < 32; i++) tick(0, 1, 0, 0, 0);
    after_edge();
    check("fw_ceiling", 32'(freq_word), 32'd65535);
    for (int i = 0; i < 45; i++) tick(0, 0, 1, 0, 0);
    after_edge();
    check("fw_floor", 32'(freq_word), 32'd1678);
    tick(0, 1, 1, 0, 0);
    after_edge();
    check("fw_both_at_floor", 32'(freq_word), 32'd1678);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    after_edge();
    check("fw_both_mid", 32'(freq_word), 32'd6712);

    // Square at shift 2, with samples from both halves of the cycle.
    full_reset();
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 130; i++) tick(1, 0, 0, 0, 0);
    idle(1);
    after_edge();
    check("square_amp2_high", 32'(dac_value), 32'd159);
    idle(1);
    after_edge();
    check("square_amp2_low", 32'(dac_value), 32'd96);

    // Reset while a sample is in flight.
    tick(0, 1, 0, 1, 1);
    mid_reset();
    idle(5);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        tick(bit'($urandom_range(0, 1)),
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 15) == 0);
      end
    end
    idle(4);
    after_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
